// File: rtl/imem_pkg.sv
// Shared constants and types for the instruction-store load controller.
// Benches import the ISA opcode constants from here as well.
package imem_pkg;

    localparam int DEPTH = 16;
    localparam int IW    = 8;
    localparam int AW    = $clog2(DEPTH);

    localparam logic [IW-1:0] NOP = 8'h00;

    // Top two instruction bits select the operation.
    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_LI    = 2'b10;
    localparam logic [1:0] OP_BNER0 = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FILL,
        DONE,
        RUN
    } imem_ctrl_state_e;

    function automatic logic is_last_slot(input logic [AW:0] ptr);
        return ptr == (AW+1)'(DEPTH - 1);
    endfunction

endpackage

// File: rtl/imem_ram.sv
// DEPTH x IW instruction store: one synchronous write port, one asynchronous read port.
// The array is deliberately not reset; validity is tracked by the controller.
module imem_ram #(
    parameter int DEPTH = 16,
    parameter int IW    = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [IW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [IW-1:0] rdata
);

    logic [IW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_load_ctrl.sv
// Sequences program load, zero-fill and CPU fetch access to the instruction store.
// cpu_instr is the only combinational output; all handshake/hold outputs are registered.
module imem_load_ctrl
    import imem_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_start,
    input  logic          ld_valid,
    input  logic [IW-1:0] ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic          ld_done,
    input  logic          run_req,
    input  logic          halt_req,
    output logic          cpu_hold,
    input  logic [AW-1:0] cpu_pc,
    output logic [IW-1:0] cpu_instr,
    output logic [AW:0]   prog_len
);

    imem_ctrl_state_e state;
    logic [AW:0]      wr_ptr;
    logic [AW:0]      wr_ptr_inc;
    logic             hs;
    logic             we;
    logic [IW-1:0]    wdata;
    logic [IW-1:0]    rdata;

    assign wr_ptr_inc = wr_ptr + 1'b1;
    // ld_ready is high exactly while in LOAD, so it qualifies the handshake.
    assign hs         = ld_ready && ld_valid;

    always_comb begin
        we    = 1'b0;
        wdata = ld_data;
        unique case (state)
            LOAD: we = hs;
            FILL: begin
                we    = 1'b1;
                wdata = NOP;
            end
            default: we = 1'b0;
        endcase
    end

    imem_ram #(
        .DEPTH (DEPTH),
        .IW    (IW),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wdata),
        .raddr (cpu_pc),
        .rdata (rdata)
    );

    assign cpu_instr = (state == RUN) ? rdata : NOP;

    // Outputs are assigned alongside the transition into the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            prog_len <= '0;
            cpu_hold <= 1'b1;
            ld_ready <= 1'b0;
            ld_done  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (load_start) begin
                        state    <= LOAD;
                        wr_ptr   <= '0;
                        ld_ready <= 1'b1;
                    end else if (run_req && prog_len != '0) begin
                        state    <= RUN;
                        cpu_hold <= 1'b0;
                    end
                end
                LOAD: begin
                    if (hs) begin
                        wr_ptr <= wr_ptr_inc;
                        if (ld_last || is_last_slot(wr_ptr)) begin
                            prog_len <= wr_ptr_inc;
                            ld_ready <= 1'b0;
                            if (is_last_slot(wr_ptr)) begin
                                state   <= DONE;
                                ld_done <= 1'b1;
                            end else begin
                                state <= FILL;
                            end
                        end
                    end
                end
                FILL: begin
                    wr_ptr <= wr_ptr_inc;
                    if (is_last_slot(wr_ptr)) begin
                        state   <= DONE;
                        ld_done <= 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    ld_done <= 1'b0;
                end
                RUN: begin
                    if (halt_req) begin
                        state    <= IDLE;
                        cpu_hold <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    cpu_hold <= 1'b1;
                    ld_ready <= 1'b0;
                    ld_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
